dmx8_4bits_reg: RTL

- Registered 1-to-8 demultiplexer and deserializer for 4-bit lanes.
- It is the distribution-side counterpart of the 4-bit 8-to-1 MUX in the ALU datapath. It takes one nibble per write and steers it into one of eight holding registers (ya..yh).
- Channel selection is either explicit, from s2/s1/s0, or automatic, from an internal round-robin counter. Automatic mode rebuilds a serialized 8-nibble frame into parallel form.

---
 rtl/dmx8_4bits_reg.sv | 81 ++++++++
 1 files changed

// File: rtl/dmx8_4bits_reg.sv
// Registered 1-to-8 demultiplexer / nibble deserializer.
// Steers each written nibble to one of eight holding registers, by explicit select or round-robin.
module dmx8_4bits_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  input  logic             wr_en,
  input  logic             auto,
  input  logic             clr,
  output logic [WIDTH-1:0] ya,
  output logic [WIDTH-1:0] yb,
  output logic [WIDTH-1:0] yc,
  output logic [WIDTH-1:0] yd,
  output logic [WIDTH-1:0] ye,
  output logic [WIDTH-1:0] yf,
  output logic [WIDTH-1:0] yg,
  output logic [WIDTH-1:0] yh,
  output logic [7:0]       load,
  output logic [2:0]       cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] y_q [8];
  logic [WIDTH-1:0] y_d [8];
  logic [7:0]       load_q, load_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;
  logic [2:0]       tgt;

  always_comb begin
    tgt          = auto ? cnt_q : {s2, s1, s0};
    y_d          = y_q;
    load_d       = '0;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (clr) begin
      // clr wins over a simultaneous write; the write is dropped
      for (int i = 0; i < 8; i++) y_d[i] = '0;
      cnt_d = '0;
    end else if (wr_en) begin
      y_d[tgt] = d;
      load_d   = 8'b1 << tgt;
      if (auto) begin
        cnt_d        = cnt_q + 3'd1;
        frame_done_d = (tgt == 3'd7);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) y_q[i] <= '0;
      load_q       <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) y_q[i] <= y_d[i];
      load_q       <= load_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ya         = y_q[0];
  assign yb         = y_q[1];
  assign yc         = y_q[2];
  assign yd         = y_q[3];
  assign ye         = y_q[4];
  assign yf         = y_q[5];
  assign yg         = y_q[6];
  assign yh         = y_q[7];
  assign load       = load_q;
  assign cnt        = cnt_q;
  assign frame_done = frame_done_q;

endmodule
